inst_memload: RTL

- Load-side counterpart of the store/memory-access stage: issues data-SRAM reads for LOAD instructions and returns a right-aligned, sign/zero-extended 32-bit result to writeback.
- Loads that cross a word boundary are split into two word reads. A one-cycle stall is raised between them, and the result is merged from both words.
- Sits between the EX/MEM pipeline register and the data SRAM read port.

---
 rtl/inst_memload.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/inst_memload.sv
// Load unit: issues data-SRAM word reads for LOAD instructions and returns a
// right-aligned, sign/zero-extended result; word-crossing loads take two reads.
module inst_memload #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              cpurst_n,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_op,
    input  logic [4:0]        ld_regindex,
    input  logic              ld_kill,
    output logic              rd_cs,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic              ld_valid,
    output logic [31:0]       ld_rdata,
    output logic [4:0]        ld_wb_regindex,
    output logic              ld_stall,
    output logic              ld_err
);

    localparam int WA_W = ADDR_W - 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_DATA2 = 2'd2;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_legal = 1'b1;
            default:                             op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_crosses(input logic [2:0] op, input logic [1:0] b);
        case (op)
            OP_LH, OP_LHU: op_crosses = (b == 2'd3);
            OP_LW:         op_crosses = (b != 2'd0);
            default:       op_crosses = 1'b0;
        endcase
    endfunction

    // src is already shifted so the addressed byte sits in bits [7:0]
    function automatic logic [31:0] extract(input logic [2:0] op, input logic [31:0] src);
        case (op)
            OP_LB:   extract = {{24{src[7]}}, src[7:0]};
            OP_LBU:  extract = {24'h000000, src[7:0]};
            OP_LH:   extract = {{16{src[15]}}, src[15:0]};
            OP_LHU:  extract = {16'h0000, src[15:0]};
            OP_LW:   extract = src;
            default: extract = 32'h00000000;
        endcase
    endfunction

    logic [1:0]      state_q, state_d;
    logic [1:0]      byte_q, byte_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      regidx_q, regidx_d;
    logic [4:0]      wb_idx_q, wb_idx_d;
    logic [WA_W-1:0] nxt_q, nxt_d;
    logic            cross_q, cross_d;
    logic [31:0]     lo_word_q, lo_word_d;
    logic            err_q, err_d;

    logic              stall_s;
    logic              accept_s;
    logic              valid_s;
    logic              rd_cs_s;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [63:0]       pair_s;
    logic [31:0]       src_s;
    logic [31:0]       rdata_s;

    // Request acceptance, SRAM read issue, result extraction and next state
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        op_d      = op_q;
        regidx_d  = regidx_q;
        nxt_d     = nxt_q;
        cross_d   = cross_q;
        lo_word_d = lo_word_q;
        wb_idx_d  = wb_idx_q;
        rd_cs_s   = 1'b0;
        rd_addr_s = {ADDR_W{1'b0}};

        stall_s  = !ld_kill && (state_q == ST_DATA) && cross_q;
        accept_s = cpurst_n && ld_req && !ld_kill && op_legal(ld_op) && !stall_s;
        valid_s  = !ld_kill && (((state_q == ST_DATA) && !cross_q) || (state_q == ST_DATA2));
        err_d    = ld_req && !ld_kill && !op_legal(ld_op) && !stall_s;

        pair_s = {rd_data, lo_word_q} >> {byte_q, 3'b000};
        if (state_q == ST_DATA2) begin
            src_s = pair_s[31:0];
        end else begin
            src_s = rd_data >> {byte_q, 3'b000};
        end

        if (accept_s) begin
            rd_cs_s   = 1'b1;
            rd_addr_s = {ld_addr[ADDR_W-1:2], 2'b00};
            byte_d    = ld_addr[1:0];
            op_d      = ld_op;
            regidx_d  = ld_regindex;
            nxt_d     = ld_addr[ADDR_W-1:2] + {{(WA_W-1){1'b0}}, 1'b1};
            cross_d   = op_crosses(ld_op, ld_addr[1:0]);
        end else if (stall_s) begin
            // second word of a crossing load; word address wraps naturally
            rd_cs_s   = 1'b1;
            rd_addr_s = {nxt_q, 2'b00};
            lo_word_d = rd_data;
        end else begin
            rd_cs_s   = 1'b0;
        end

        if (valid_s) begin
            rdata_s  = extract(op_q, src_s);
            wb_idx_d = regidx_q;
        end else begin
            rdata_s  = 32'h00000000;
        end

        if (ld_kill) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = accept_s ? ST_DATA : ST_IDLE;
                ST_DATA:  state_d = cross_q ? ST_DATA2 : (accept_s ? ST_DATA : ST_IDLE);
                ST_DATA2: state_d = accept_s ? ST_DATA : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // State and holding registers
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state_q   <= ST_IDLE;
            byte_q    <= 2'b00;
            op_q      <= 3'b000;
            regidx_q  <= 5'd0;
            wb_idx_q  <= 5'd0;
            nxt_q     <= {WA_W{1'b0}};
            cross_q   <= 1'b0;
            lo_word_q <= 32'h00000000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            op_q      <= op_d;
            regidx_q  <= regidx_d;
            wb_idx_q  <= wb_idx_d;
            nxt_q     <= nxt_d;
            cross_q   <= cross_d;
            lo_word_q <= lo_word_d;
            err_q     <= err_d;
        end
    end

    assign rd_cs          = rd_cs_s;
    assign rd_addr        = rd_addr_s;
    assign ld_valid       = valid_s;
    assign ld_rdata       = rdata_s;
    assign ld_wb_regindex = valid_s ? regidx_q : wb_idx_q;
    assign ld_stall       = stall_s;
    assign ld_err         = err_q;

endmodule
